divisor_secuencial: RTL and testbench
=====================================

// Module: divisor_secuencial
// PURPOSE
//  Sequential shift/subtract (restoring) divider, the inverse operation of the team's sequential multiplier.
//  Splits into a datapath (A/Q/M registers, subtractor) and a control unit, as the multiplier does.
//  Accepts dividend/divisor on a start strobe, iterates one quotient bit per clock, raises Fin with results.
// PARAMETERS
//  N  4  operand width in bits; dividend, divisor, quotient and remainder are all N bits.
// PORTS
//  clk          in   1  single clock; all state changes on rising edge.
//  reset        in   1  asynchronous, active-low reset (0 = reset).
//  dividendo    in   N  dividend; sampled only at the start-capture edge.
//  divisor      in   N  divisor; sampled only at the start-capture edge.
//  start        in   1  request; sampled in IDLE or DONE.
//  cociente     out  N  quotient; registered, stable while Fin=1.
//  resto        out  N  remainder; registered, stable while Fin=1.
//  div_cero     out  1  divisor was zero for the current result.
//  ocupado      out  1  high in ITER and FIX.
//  Fin          out  1  result valid; level, held in DONE.
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-operation): state IDLE; cociente, resto, div_cero, ocupado, Fin all 0; internal A, Q, M and count cleared.
//  - States: IDLE, ITER, FIX, DONE.
//  - IDLE/DONE + start=1 at edge E0: capture operands into M (divisor) and Q (dividend), A=0, count=0.
//    Fin and div_cero drop at E0.
//    If divisor==0: go to DONE; cociente=all ones, resto=dividendo, div_cero=1, so Fin=1 one cycle after E0.
//    Otherwise go to ITER.
//  - ITER, one edge per bit, N edges:
//    {A,Q} <<= 1; T = A - M on N+1 bits.
//    If T >= 0: A=T, Q[0]=1; else Q[0]=0 (restore).
//    count++; after the N-th iteration go to FIX.
//  - FIX (1 edge): copy Q to cociente and A to resto (sign correction when signed); go to DONE.
//  - Latency: Fin=1 after edge E0+N+1, i.e. 5 cycles for N=4. Divide-by-zero takes 1 cycle.
//  - DONE: Fin=1, outputs frozen; stays until a new start. start=0 in DONE keeps DONE; there is no auto-return to IDLE.
//  - start=1 while ocupado=1 is ignored; operand changes during ITER/FIX have no effect.
//  - A is N+1 bits internally so the compare/subtract never overflows. Outputs are truncated to N bits.
// CONFIGURATION
//  SIGNED_DIV_EN defined: operands and results are two's complement.
//    The unsigned core runs on magnitudes.
//    FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative.
//    Truncation is toward zero; the remainder takes the dividend's sign.
//    Overflow case -2^(N-1) / -1 gives cociente=-2^(N-1) (wrap), resto=0, div_cero=0.
//    Divide by zero gives cociente=all ones (-1), resto=dividendo.
//  SIGNED_DIV_EN undefined: purely unsigned; no sign logic is synthesised; latency is identical in both modes.
// STRUCTURE
//  Shared package/include divisor_pkg: state encoding constants (IDLE, ITER, FIX, DONE), width of the count register $clog2(N+1).
//  Sub-module divisor_uc: FSM plus counter.
//    Outputs the control strobes carga, desplaza, resta_ok, corrige and fin.
//    Input: the sign of T from the datapath.
//  The datapath is kept in the top module.
// TESTING
//  1 unsigned 13/4: start at E0 -> Fin at E0+5, cociente=3, resto=1, div_cero=0; ocupado high for exactly 5 cycles.
//  2 unsigned 15/1 -> 15 r 0; 3/9 -> 0 r 3; 9/9 -> 1 r 0; exhaustive 16x15 sweep against a behavioural model.
//  3 7/0 -> Fin one cycle after E0, cociente=4'hF, resto=7, div_cero=1; a following 6/3 clears div_cero and gives 2 r 0.
//  4 reset=0 during ITER (count=2) -> all outputs 0 at once (asynchronous); after release, start 10/3 -> 3 r 1.
//  5 start re-pulsed and operands changed during ITER -> ignored; result of the original operands is unchanged.
//  6 SIGNED_DIV_EN:
//    -7/2 -> cociente=4'b1101 (-3), resto=4'b1111 (-1).
//    7/-2 -> -3 r 1.
//    -8/-1 -> cociente=4'b1000, resto=0.
//    -8/0 -> div_cero=1, cociente=4'hF, resto=4'b1000.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
// States, the default operand width and the iteration-counter width.
package divisor_pkg;

  localparam int unsigned N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } estado_t;

  // Counter width able to hold 0..n
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divisor_uc.sv
// Control unit of the restoring divider: state machine and iteration counter.
// Produces the datapath strobes carga, desplaza, resta_ok, corrige and fin.
module divisor_uc
  import divisor_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic cero_i,
  input  logic t_neg_i,
  output logic carga_c,
  output logic desplaza_c,
  output logic resta_ok_c,
  output logic corrige_c,
  output logic fin_c
);

  localparam int unsigned CW = cnt_w(N);

  estado_t       state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          acepta_c;

  // A start is only honoured while not busy
  assign acepta_c = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (acepta_c) begin
          count_d = '0;
          state_d = cero_i ? ST_DONE : ST_ITER;
        end
      end
      ST_ITER: begin
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decoded from the current state
  always_comb begin
    carga_c    = acepta_c;
    desplaza_c = (state_q == ST_ITER);
    resta_ok_c = desplaza_c && !t_neg_i;
    corrige_c  = (state_q == ST_FIX);
    // Fin rises on the FIX edge, or one edge after a divide-by-zero lands in DONE
    fin_c      = corrige_c || ((state_q == ST_DONE) && !start_i);
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential shift/subtract (restoring) divider, one quotient bit per clock.
// Datapath (A/Q/M, subtractor, result registers) lives here; control is divisor_uc.
// Optional macro SIGNED_DIV_EN: two's-complement operands, core runs on magnitudes.
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  input  logic         start,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         div_cero,
  output logic         ocupado,
  output logic         Fin
);

  logic [N:0]   a_q, a_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_q, m_d;
  logic [N+1:0] a_sh, t_c;
  logic [N-1:0] mag_dvd, mag_dvs, coc_fix, res_fix;
  logic         cero_c;
  logic         carga_c, desplaza_c, resta_ok_c, corrige_c, fin_c;

  logic [N-1:0] cociente_q, cociente_d;
  logic [N-1:0] resto_q, resto_d;
  logic         div_cero_q, div_cero_d;
  logic         ocupado_q, ocupado_d;
  logic         fin_q, fin_d;

  assign cero_c = (divisor == '0);

  // Shifted partial remainder and trial subtraction, one spare bit so the sign is exact
  assign a_sh = {a_q, q_q[N-1]};
  assign t_c  = a_sh - {2'b00, m_q};

`ifdef SIGNED_DIV_EN
  logic neg_coc_q, neg_coc_d, neg_res_q, neg_res_d;

  assign mag_dvd = dividendo[N-1] ? (N'(0) - dividendo) : dividendo;
  assign mag_dvs = divisor[N-1]   ? (N'(0) - divisor)   : divisor;

  // Result signs remembered from the captured operands
  always_comb begin
    neg_coc_d = neg_coc_q;
    neg_res_d = neg_res_q;
    if (carga_c) begin
      neg_coc_d = dividendo[N-1] ^ divisor[N-1];
      neg_res_d = dividendo[N-1];
    end
  end

  // Sign flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_coc_q <= 1'b0;
      neg_res_q <= 1'b0;
    end else begin
      neg_coc_q <= neg_coc_d;
      neg_res_q <= neg_res_d;
    end
  end

  assign coc_fix = neg_coc_q ? (N'(0) - q_q) : q_q;
  assign res_fix = neg_res_q ? (N'(0) - a_q[N-1:0]) : a_q[N-1:0];
`else
  assign mag_dvd = dividendo;
  assign mag_dvs = divisor;
  assign coc_fix = q_q;
  assign res_fix = a_q[N-1:0];
`endif

  divisor_uc #(.N(N)) u_uc (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .cero_i     (cero_c),
    .t_neg_i    (t_c[N+1]),
    .carga_c    (carga_c),
    .desplaza_c (desplaza_c),
    .resta_ok_c (resta_ok_c),
    .corrige_c  (corrige_c),
    .fin_c      (fin_c)
  );

  // A/Q/M update: load on capture, shift and conditionally subtract while iterating
  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    if (carga_c) begin
      a_d = '0;
      q_d = mag_dvd;
      m_d = mag_dvs;
    end else if (desplaza_c) begin
      a_d = resta_ok_c ? t_c[N:0] : a_sh[N:0];
      q_d = {q_q[N-2:0], resta_ok_c};
    end
  end

  // Result and status update
  always_comb begin
    cociente_d = cociente_q;
    resto_d    = resto_q;
    div_cero_d = div_cero_q;
    ocupado_d  = ocupado_q;
    fin_d      = fin_c;
    if (carga_c) begin
      div_cero_d = cero_c;
      ocupado_d  = !cero_c;
      if (cero_c) begin
        cociente_d = '1;
        resto_d    = dividendo;
      end
    end else if (corrige_c) begin
      cociente_d = coc_fix;
      resto_d    = res_fix;
      ocupado_d  = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cociente_q <= '0;
      resto_q    <= '0;
      div_cero_q <= 1'b0;
      ocupado_q  <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      div_cero_q <= div_cero_d;
      ocupado_q  <= ocupado_d;
      fin_q      <= fin_d;
    end
  end

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign div_cero = div_cero_q;
  assign ocupado  = ocupado_q;
  assign Fin      = fin_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (unsigned, or signed with SIGNED_DIV_EN).
module tb_divisor_secuencial;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividendo, divisor;
  logic [3:0] cociente, resto;
  logic       div_cero, ocupado, Fin;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q, exp_r;
  logic       exp_z;
  bit         exp_valid = 1'b0;

  always #5 clk = ~clk;

  divisor_secuencial #(.N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .dividendo (dividendo),
    .divisor   (divisor),
    .start     (start),
    .cociente  (cociente),
    .resto     (resto),
    .div_cero  (div_cero),
    .ocupado   (ocupado),
    .Fin       (Fin)
  );

  // Reference: plain integer division (truncating toward zero)
  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic z);
    int sa, sb, qi, ri;
    logic [31:0] tq, tr;
    if (b == 4'd0) begin
      q = 4'hF;
      r = a;
      z = 1'b1;
      return;
    end
`ifdef SIGNED_DIV_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    qi = sa / sb;
    ri = sa % sb;
    tq = qi;
    tr = ri;
    q  = tq[3:0];
    r  = tr[3:0];
    z  = 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Whenever a result is flagged valid it must match the model
  always @(negedge clk) begin
    if (exp_valid && reset && Fin) begin
      check("cmp_cociente", 32'(cociente), 32'(exp_q));
      check("cmp_resto",    32'(resto),    32'(exp_r));
      check("cmp_div_cero", 32'(div_cero), 32'(exp_z));
    end
  end

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    model(a, b, exp_q, exp_r, exp_z);
    exp_valid = 1'b1;
    #1 start = 1'b0;
  endtask

  // Called just after E0; measures edges until Fin and cycles with ocupado high
  task automatic wait_fin(input string name, input int exp_lat, input int exp_busy);
    int cyc  = 0;
    int busy = 0;
    check({name, "_fin_drop"}, 32'(Fin), 32'd0);
    if (ocupado) busy++;
    while (!Fin && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ocupado) busy++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic lit(input string name, input logic [3:0] q, input logic [3:0] r, input logic z);
    check({name, "_cociente"}, 32'(cociente), 32'(q));
    check({name, "_resto"},    32'(resto),    32'(r));
    check({name, "_div_cero"}, 32'(div_cero), 32'(z));
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    start     = 1'b0;
    dividendo = 4'd0;
    divisor   = 4'd0;
    #12;
    check("rst_cociente", 32'(cociente), 32'd0);
    check("rst_resto",    32'(resto),    32'd0);
    check("rst_div_cero", 32'(div_cero), 32'd0);
    check("rst_ocupado",  32'(ocupado),  32'd0);
    check("rst_fin",      32'(Fin),      32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifndef SIGNED_DIV_EN
    launch(4'd13, 4'd4); wait_fin("u13_4", 5, 5); lit("u13_4", 4'd3, 4'd1, 1'b0);
    repeat (3) @(negedge clk);
    check("done_hold_fin", 32'(Fin), 32'd1);
    check("done_hold_q",   32'(cociente), 32'd3);
    launch(4'd15, 4'd1); wait_fin("u15_1", 5, 5); lit("u15_1", 4'd15, 4'd0, 1'b0);
    launch(4'd3,  4'd9); wait_fin("u3_9",  5, 5); lit("u3_9",  4'd0,  4'd3, 1'b0);
    launch(4'd9,  4'd9); wait_fin("u9_9",  5, 5); lit("u9_9",  4'd1,  4'd0, 1'b0);
    launch(4'd7,  4'd0); wait_fin("u7_0",  1, 0); lit("u7_0",  4'hF,  4'd7, 1'b1);
    launch(4'd6,  4'd3);
    check("dz_clear", 32'(div_cero), 32'd0);
    wait_fin("u6_3", 5, 5); lit("u6_3", 4'd2, 4'd0, 1'b0);
`else
    launch(4'b1001, 4'd2);    wait_fin("s_m7_2",  5, 5); lit("s_m7_2",  4'b1101, 4'b1111, 1'b0);
    launch(4'b0111, 4'b1110); wait_fin("s_7_m2",  5, 5); lit("s_7_m2",  4'b1101, 4'b0001, 1'b0);
    launch(4'b1000, 4'b1111); wait_fin("s_m8_m1", 5, 5); lit("s_m8_m1", 4'b1000, 4'b0000, 1'b0);
    launch(4'b1000, 4'd0);    wait_fin("s_m8_0",  1, 0); lit("s_m8_0",  4'hF,    4'b1000, 1'b1);
    launch(4'd6, 4'd3);
    check("dz_clear", 32'(div_cero), 32'd0);
    wait_fin("s6_3", 5, 5); lit("s6_3", 4'd2, 4'd0, 1'b0);
`endif

    // Asynchronous reset in the middle of ITER (after two iterations)
    launch(4'd11, 4'd2);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    exp_valid = 1'b0;
    check("arst_cociente", 32'(cociente), 32'd0);
    check("arst_resto",    32'(resto),    32'd0);
    check("arst_div_cero", 32'(div_cero), 32'd0);
    check("arst_ocupado",  32'(ocupado),  32'd0);
    check("arst_fin",      32'(Fin),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    launch(4'd10, 4'd3); wait_fin("post_rst", 5, 5);
`ifndef SIGNED_DIV_EN
    lit("post_rst", 4'd3, 4'd1, 1'b0);
`else
    lit("post_rst", 4'b1110, 4'd0, 1'b0);
`endif

    // start re-pulsed with new operands while busy must be ignored
    launch(4'd14, 4'd3);
    @(negedge clk);
    start     = 1'b1;
    dividendo = 4'd1;
    divisor   = 4'd1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!Fin && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_start_latency", 32'(cyc), 32'd3);
`ifndef SIGNED_DIV_EN
    lit("busy_start", 4'd4, 4'd2, 1'b0);
`else
    lit("busy_start", 4'd0, 4'b1110, 1'b0);
`endif

    // Full sweep of non-zero divisors against the model
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(4'(a), 4'(b));
        wait_fin("sweep", 5, 5);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
